// File: rtl/op_sequencer.sv
// Walks the set bits of an opcode mask in ascending order, holding each opcode
// on the mux_case unit for DWELL cycles before sampling its result for a consumer.
module op_sequencer #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic [7:0] op_mask,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] N,
    input  logic [3:0] X,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [2:0] res_n,
    output logic [3:0] res_x,
    output logic       busy,
    output logic       done,
    output logic [7:0] sig,
    output logic [3:0] count
);

    localparam logic [3:0] DWELL_LD = 4'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] mask_q, mask_d;
    logic [3:0] dwell_q, dwell_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [2:0] n_q, n_d;
    logic [2:0] res_n_q, res_n_d;
    logic [3:0] res_x_q, res_x_d;
    logic [7:0] sig_q, sig_d;
    logic [3:0] count_q, count_d;
    logic [7:0] mask_left;

    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) lowest_bit = 3'(k);
        end
    endfunction

    // Mask with the opcode being handed off removed; decides whether the run continues.
    assign mask_left = mask_q & ~(8'b1 << res_n_q);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        res_n_d = res_n_q;
        res_x_d = res_x_q;
        sig_d   = sig_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sig_d   = 8'h00;
                    count_d = 4'd0;
                    if (op_mask != 8'h00) begin
                        mask_d  = op_mask;
                        a_d     = a_in;
                        b_d     = b_in;
                        n_d     = lowest_bit(op_mask);
                        dwell_d = DWELL_LD;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SETTLE: begin
                if (dwell_q == 4'd0) begin
                    res_x_d = X;
                    res_n_d = n_q;
                    state_d = S_CAPTURE;
                end else begin
                    dwell_d = dwell_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                if (res_ready) begin
                    sig_d   = {sig_q[6:0], sig_q[7]} ^ {1'b0, res_n_q, res_x_q};
                    count_d = count_q + 4'd1;
                    mask_d  = mask_left;
                    if (mask_left != 8'h00) begin
                        n_d     = lowest_bit(mask_left);
                        dwell_d = DWELL_LD;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= 8'h00;
            dwell_q <= 4'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            n_q     <= 3'd0;
            res_n_q <= 3'd0;
            res_x_q <= 4'd0;
            sig_q   <= 8'h00;
            count_q <= 4'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            res_n_q <= res_n_d;
            res_x_q <= res_x_d;
            sig_q   <= sig_d;
            count_q <= count_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign N         = n_q;
    assign res_n     = res_n_q;
    assign res_x     = res_x_q;
    assign sig       = sig_q;
    assign count     = count_q;
    assign res_valid = (state_q == S_CAPTURE);
    assign busy      = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: queue-based run model checked every cycle, directed
// scenarios with literal expectations, then a randomized stretch.
module tb_op_sequencer;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a_in = 4'd0;
    logic [3:0] b_in = 4'd0;
    logic [7:0] op_mask = 8'h00;
    logic       res_ready = 1'b0;
    logic [3:0] A, B, X, res_x, count;
    logic [2:0] N, res_n;
    logic       res_valid, busy, done;
    logic [7:0] sig;

    always #5 clk = ~clk;

    // mux_case stand-in
    assign X = A ^ {1'b0, N};

    op_sequencer #(.DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .op_mask(op_mask), .A(A), .B(B), .N(N), .X(X), .res_valid(res_valid),
        .res_ready(res_ready), .res_n(res_n), .res_x(res_x), .busy(busy),
        .done(done), .sig(sig), .count(count)
    );

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a run is a queue of pending opcodes; each opcode waits
    // DWELL cycles, then is offered until accepted.
    logic [3:0] m_a = 0, m_b = 0, m_resx = 0, m_count = 0;
    logic [2:0] m_n = 0, m_resn = 0;
    logic [7:0] m_sig = 0;
    bit         m_valid = 0, m_busy = 0, m_done = 0;
    int         settle_left = 0;
    int         pend[$];
    int         log_q[$];

    task automatic model_step();
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_n = 0; m_resn = 0; m_resx = 0;
            m_sig = 0; m_count = 0; m_valid = 0; m_busy = 0; m_done = 0;
            settle_left = 0;
            pend.delete();
        end else if (m_done) begin
            m_done = 0;
        end else if (m_valid) begin
            if (res_ready) begin
                m_sig = {m_sig[6:0], m_sig[7]} ^ {1'b0, m_resn, m_resx};
                m_count = m_count + 4'd1;
                log_q.push_back(int'(m_resn) * 16 + int'(m_resx));
                m_valid = 0;
                if (pend.size() > 0) begin
                    m_n = 3'(pend.pop_front());
                    settle_left = DWELL;
                end else begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (m_busy) begin
            settle_left--;
            if (settle_left == 0) begin
                m_resn = m_n;
                m_resx = m_a ^ {1'b0, m_n};
                m_valid = 1;
            end
        end else if (start) begin
            m_sig = 0;
            m_count = 0;
            if (op_mask == 8'h00) begin
                m_done = 1;
            end else begin
                m_a = a_in;
                m_b = b_in;
                pend.delete();
                for (int k = 0; k < 8; k++) if (op_mask[k]) pend.push_back(k);
                m_n = 3'(pend.pop_front());
                settle_left = DWELL;
                m_busy = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("A", A, m_a);
            chk("B", B, m_b);
            chk("N", N, m_n);
            chk("res_valid", res_valid, m_valid);
            chk("res_n", res_n, m_resn);
            chk("res_x", res_x, m_resx);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("sig", sig, m_sig);
            chk("count", count, m_count);
            chk("valid_done_excl", res_valid & done, 0);
            if (done) done_cnt++;
        end
    end

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", n < budget, 1);
    endtask

    task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic [7:0] m);
        @(negedge clk);
        start = 1; a_in = a; b_in = b; op_mask = m;
        @(negedge clk);
        start = 0;
    endtask

    task automatic check_log(input string name, input int exp[$]);
        chk({name, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk(name, log_q[i], exp[i]);
    endtask

    int n;

    initial begin
        res_ready = 1;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_count", count, 0);
        rst_n = 1;

        // Five-opcode run, always-ready consumer
        log_q.delete(); done_cnt = 0;
        launch(4'd6, 4'd5, 8'h4F);
        wait_done(200, n);
        check_log("run4F", '{8'h06, 8'h17, 8'h24, 8'h35, 8'h60});
        chk("run4F_count", count, 5);
        chk("run4F_sig", sig, 8'h42);
        @(negedge clk);
        chk("run4F_done_pulses", done_cnt, 1);

        // Single opcode
        log_q.delete();
        launch(4'd6, 4'd0, 8'h01);
        wait_done(100, n);
        chk("run01_resx", res_x, 6);
        chk("run01_resn", res_n, 0);
        chk("run01_sig", sig, 8'h06);
        chk("run01_count", count, 1);
        @(negedge clk);

        // Empty mask: done on the next cycle, nothing else
        log_q.delete();
        launch(4'd3, 4'd3, 8'h00);
        wait_done(10, n);
        chk("empty_done_latency", n, 0);
        chk("empty_count", count, 0);
        chk("empty_log", log_q.size(), 0);
        @(negedge clk);

        // Consumer stall in the first capture
        log_q.delete();
        res_ready = 0;
        launch(4'd6, 4'd1, 8'h03);
        n = 0;
        while (!res_valid && n < 50) begin @(negedge clk); n++; end
        chk("stall_reach", n < 50, 1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", res_valid, 1);
            chk("stall_resx", res_x, 6);
            chk("stall_N", N, 0);
            chk("stall_count", count, 0);
            @(negedge clk);
        end
        res_ready = 1;
        wait_done(100, n);
        check_log("stall", '{8'h06, 8'h17});
        @(negedge clk);

        // Reset during SETTLE aborts the run
        launch(4'd5, 4'd2, 8'hFF);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("abort_busy", busy, 0);
        chk("abort_A", A, 0);
        chk("abort_count", count, 0);
        chk("abort_sig", sig, 0);
        chk("abort_done", done, 0);
        log_q.delete();
        launch(4'd6, 4'd0, 8'h01);
        wait_done(100, n);
        chk("after_abort_count", count, 1);
        chk("after_abort_sig", sig, 8'h06);
        @(negedge clk);

        // Start during SETTLE is ignored
        log_q.delete();
        launch(4'd3, 4'd0, 8'h01);
        start = 1; a_in = 4'd9; op_mask = 8'h80;
        @(negedge clk);
        start = 0;
        wait_done(100, n);
        check_log("ignore_start", '{8'h03});
        chk("ignore_A", A, 3);
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            start     = ($urandom_range(0, 3) == 0);
            a_in      = 4'($urandom);
            b_in      = 4'($urandom);
            op_mask   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        rst_n = 1; start = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
